// File: rtl/sys_pkg.sv
// Shared definitions for the processor-system sequencer: opcodes, FSM states, default widths.
package sys_pkg;

  localparam int SYS_ADDR_W = 5;
  localparam int SYS_DATA_W = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_LATCH_IMM,
    S_ISSUE,
    S_SEND_IMM,
    S_WAIT_DONE,
    S_HALTED,
    S_ERROR
  } seq_state_t;

  function automatic logic is_busy(input seq_state_t s);
    return !(s inside {S_IDLE, S_HALTED, S_ERROR});
  endfunction

endpackage

// File: rtl/done_watchdog.sv
// Done watchdog: counts enabled cycles; expired marks the TIMEOUT-th one so the caller leaves on that edge.
// Latency 0 from cnt to expired; no flow control.
module done_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches instructions (plus mvi immediates) from a sync ROM and issues them to the control FSM.
// run appears 3 edges after start (5 for mvi); each instruction waits for done, guarded by a watchdog.
module prog_sequencer
  import sys_pkg::*;
#(
  parameter int ADDR_W  = SYS_ADDR_W,
  parameter int DATA_W  = SYS_DATA_W,
  parameter int ROM_LAT = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              step_mode,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam int LW = 4;

  seq_state_t        state;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] imm;
  logic [LW-1:0]     lat_cnt;
  logic              lat_last;
  logic              instr_mvi;
  logic              wd_expired;
  logic [2:0]        rom_op;
  logic [ADDR_W-1:0] pc_ret;
  seq_state_t        ret_state;

  assign lat_last  = (lat_cnt == LW'(ROM_LAT - 1));
  assign rom_op    = rom_data[DATA_W-1 -: 3];
  assign instr_mvi = (instr[DATA_W-1 -: 3] == OP_MVI);
  // mvi consumes two words, so it skips over its immediate
  assign pc_ret    = pc + (instr_mvi ? ADDR_W'(2) : ADDR_W'(1));
  assign ret_state = halt_req ? S_HALTED : (step_mode ? S_IDLE : S_FETCH);

  assign busy   = is_busy(state);
  assign halted = (state == S_HALTED);
  assign error  = (state == S_ERROR);

  done_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (state != S_WAIT_DONE),
    .en      (state == S_WAIT_DONE),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      pc          <= '0;
      rom_addr    <= '0;
      din         <= '0;
      run         <= 1'b0;
      instr_count <= '0;
      instr       <= '0;
      imm         <= '0;
      lat_cnt     <= '0;
    end else begin
      run <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rom_addr <= pc;
            state    <= S_FETCH;
          end else if (halt_req) begin
            state <= S_HALTED;
          end
        end
        S_HALTED, S_ERROR: begin
          if (start) begin
            pc       <= '0;
            rom_addr <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (lat_last) begin
            lat_cnt <= '0;
            state   <= S_DECODE;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_DECODE: begin
          instr <= rom_data;
          if (rom_op == OP_HALT) begin
            state <= S_HALTED;
          end else if (rom_op == OP_MVI) begin
            rom_addr <= pc + ADDR_W'(1);
            state    <= S_FETCH_IMM;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_FETCH_IMM: begin
          if (lat_last) begin
            lat_cnt <= '0;
            state   <= S_LATCH_IMM;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_LATCH_IMM: begin
          imm   <= rom_data;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          din   <= instr;
          run   <= 1'b1;
          state <= instr_mvi ? S_SEND_IMM : S_WAIT_DONE;
        end
        S_SEND_IMM: begin
          din <= imm;
          if (done) begin
            pc          <= pc_ret;
            rom_addr    <= pc_ret;
            instr_count <= instr_count + 8'd1;
            state       <= ret_state;
          end else begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (done) begin
            pc          <= pc_ret;
            rom_addr    <= pc_ret;
            instr_count <= instr_count + 8'd1;
            state       <= ret_state;
          end else if (wd_expired) begin
            state <= S_ERROR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
